// File: rtl/wifi_tx_punct_stream_fifo.sv
// Synchronous FIFO between the convolutional encoder and the puncturer, with level, threshold
// flags and flush. Define WIFI_PUNCT_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module wifi_tx_punct_stream_fifo #(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned AD        = 14,
  parameter int unsigned AF_THRESH = 2**AD - 4,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              valid_out_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
`ifdef WIFI_PUNCT_FIFO_ERR_EN
  output logic              overflow_o,
  output logic              underflow_o,
`endif
  output logic [AD:0]       level_o
);

  localparam int unsigned Depth    = 2**AD;
  localparam logic [AD:0] DepthLvl = (AD+1)'(Depth);
  localparam logic [AD:0] AfLvl    = (AD+1)'(AF_THRESH);
  localparam logic [AD:0] AeLvl    = (AD+1)'(AE_THRESH);

  logic [DATA_W-1:0] ram_q [Depth];

  logic [AD-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AD-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AD:0]       level_q, level_d;
  logic [DATA_W-1:0] data_out_q;
  logic              valid_q;
  logic              wr_acc, rd_acc;

  assign full_o         = (level_q == DepthLvl);
  assign empty_o        = (level_q == '0);
  assign almost_full_o  = (level_q >= AfLvl);
  assign almost_empty_o = (level_q <= AeLvl);
  assign level_o        = level_q;
  assign data_out_o     = data_out_q;
  assign valid_out_o    = valid_q;

  // A read at full frees a slot in the same cycle, so the write is also accepted.
  assign rd_acc = re_i & ~empty_o;
  assign wr_acc = we_i & (~full_o | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= rd_acc;
      if (rd_acc) data_out_q <= ram_q[rd_ptr_q];
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && wr_acc) ram_q[wr_ptr_q] <= data_in_i;
  end

`ifdef WIFI_PUNCT_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we_i && full_o && !rd_acc) overflow_q <= 1'b1;
      if (re_i && empty_o) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_wifi_tx_punct_stream_fifo.sv
// Directed bench for wifi_tx_punct_stream_fifo at DATA_W=8, AD=4 (depth 16).
module tb_wifi_tx_punct_stream_fifo;

  logic       clk = 1'b0;
  logic       reset, flush, we, re;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [4:0] level;
`ifdef WIFI_PUNCT_FIFO_ERR_EN
  logic       overflow, underflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wifi_tx_punct_stream_fifo #(
    .DATA_W   (8),
    .AD       (4),
    .AF_THRESH(12),
    .AE_THRESH(4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .flush_i       (flush),
    .we_i          (we),
    .data_in_i     (data_in),
    .re_i          (re),
    .data_out_o    (data_out),
    .valid_out_o   (valid_out),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full),
    .almost_empty_o(almost_empty),
`ifdef WIFI_PUNCT_FIFO_ERR_EN
    .overflow_o    (overflow),
    .underflow_o   (underflow),
`endif
    .level_o       (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; data_in = 8'h00;
    #1;
    step();
    reset = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);

    // 1: fill to full, then an overflowing write
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; data_in = 8'(i);
      step();
      chk("t1_level", 32'(level), 32'(i + 1));
      chk("t1_af", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("t1_ae", 32'(almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
    end
    chk("t1_full", 32'(full), 32'd1);
    data_in = 8'hAA;
    step();
    we = 1'b0;
    chk("t1_ovf_level", 32'(level), 32'd16);
    chk("t1_ovf_full", 32'(full), 32'd1);
`ifdef WIFI_PUNCT_FIFO_ERR_EN
    chk("t1_overflow", 32'(overflow), 32'd1);
`endif

    // 2: drain 16, then an underflowing read
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      step();
      chk("t2_dout", 32'(data_out), 32'(i));
      chk("t2_valid", 32'(valid_out), 32'd1);
    end
    chk("t2_empty", 32'(empty), 32'd1);
    step();
    re = 1'b0;
    chk("t2_uf_valid", 32'(valid_out), 32'd0);
    chk("t2_uf_dout", 32'(data_out), 32'h0F);
    chk("t2_uf_level", 32'(level), 32'd0);
`ifdef WIFI_PUNCT_FIFO_ERR_EN
    chk("t2_underflow", 32'(underflow), 32'd1);
`endif

    // 3: simultaneous read/write at full
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; data_in = 8'(8'h10 + i);
      step();
    end
    chk("t3_full", 32'(full), 32'd1);
    we = 1'b1; re = 1'b1; data_in = 8'h55;
    step();
    we = 1'b0;
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_dout", 32'(data_out), 32'h10);
    chk("t3_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t3_drain", 32'(data_out), (i == 15) ? 32'h55 : 32'(8'h11 + i));
    end
    re = 1'b0;
    chk("t3_empty", 32'(level), 32'd0);

    // 4: simultaneous read/write at empty
    we = 1'b1; re = 1'b1; data_in = 8'h33;
    step();
    we = 1'b0;
    chk("t4_valid", 32'(valid_out), 32'd0);
    chk("t4_level", 32'(level), 32'd1);
    step();
    re = 1'b0;
    chk("t4_dout", 32'(data_out), 32'h33);
    chk("t4_rvalid", 32'(valid_out), 32'd1);
    chk("t4_level0", 32'(level), 32'd0);

    // 5: advance pointers, then cross the 15->0 wrap
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; data_in = 8'(8'h40 + i);
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      re = 1'b1;
      step();
      chk("t5_pre", 32'(data_out), 32'(8'h40 + i));
    end
    re = 1'b0;
    for (int i = 0; i < 12; i++) begin
      we = 1'b1; data_in = 8'(8'h80 + i);
      step();
    end
    we = 1'b0;
    chk("t5_level12", 32'(level), 32'd12);
    for (int i = 0; i < 12; i++) begin
      re = 1'b1;
      step();
      chk("t5_wrap", 32'(data_out), 32'(8'h80 + i));
    end
    re = 1'b0;
    chk("t5_level0", 32'(level), 32'd0);

    // 6a: flush at level 7 with write and read requested
    for (int i = 0; i < 7; i++) begin
      we = 1'b1; data_in = 8'(8'hC0 + i);
      step();
    end
    chk("t6_level7", 32'(level), 32'd7);
    flush = 1'b1; we = 1'b1; re = 1'b1; data_in = 8'hEE;
    step();
    flush = 1'b0; we = 1'b0; re = 1'b0;
    chk("t6_fl_level", 32'(level), 32'd0);
    chk("t6_fl_empty", 32'(empty), 32'd1);
    chk("t6_fl_valid", 32'(valid_out), 32'd0);
    chk("t6_fl_dout", 32'(data_out), 32'h8B);
    we = 1'b1; data_in = 8'h77;
    step();
    we = 1'b0; re = 1'b1;
    step();
    re = 1'b0;
    chk("t6_post_fl", 32'(data_out), 32'h77);

    // 6b: reset mid-burst at level 9
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; data_in = 8'(8'hD0 + i);
      step();
    end
    chk("t6_level9", 32'(level), 32'd9);
    reset = 1'b1; we = 1'b1; re = 1'b1;
    step();
    reset = 1'b0; we = 1'b0; re = 1'b0;
    chk("t6_rs_level", 32'(level), 32'd0);
    chk("t6_rs_empty", 32'(empty), 32'd1);
    chk("t6_rs_ae", 32'(almost_empty), 32'd1);
    chk("t6_rs_af", 32'(almost_full), 32'd0);
    chk("t6_rs_valid", 32'(valid_out), 32'd0);
    chk("t6_rs_dout", 32'(data_out), 32'd0);
`ifdef WIFI_PUNCT_FIFO_ERR_EN
    chk("t6_rs_ovf", 32'(overflow), 32'd0);
    chk("t6_rs_udf", 32'(underflow), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
